// File: rtl/id_stage.sv
// Instruction decode stage: 32x32 register file with writeback bypass, field
// decode, load-use hazard detection and the ID/EX pipeline register.
module id_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic [5:0]  opcode,
    output logic [31:0] rs_content,
    output logic [31:0] rt_content,
    output logic [4:0]  shamt,
    output logic [5:0]  ALU_control,
    output logic [15:0] immediate,
    output logic [4:0]  dest_addr,
    output logic        ex_valid,
    output logic        hazard
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LOAD  = 6'b100011;

    logic [31:0] rf_q [32];

    logic [5:0]  op_f;
    logic [4:0]  rs_f, rt_f, rd_f, sh_f;
    logic [5:0]  fn_f;
    logic [15:0] imm_f;
    logic [31:0] rs_val, rt_val;
    logic        wb_live;

    logic [5:0]  opcode_q, opcode_d;
    logic [31:0] rs_content_q, rs_content_d;
    logic [31:0] rt_content_q, rt_content_d;
    logic [4:0]  shamt_q, shamt_d;
    logic [5:0]  alu_ctrl_q, alu_ctrl_d;
    logic [15:0] immediate_q, immediate_d;
    logic [4:0]  dest_addr_q, dest_addr_d;
    logic        ex_valid_q, ex_valid_d;

    assign op_f  = instr[31:26];
    assign rs_f  = instr[25:21];
    assign rt_f  = instr[20:16];
    assign rd_f  = instr[15:11];
    assign sh_f  = instr[10:6];
    assign fn_f  = instr[5:0];
    assign imm_f = instr[15:0];

    // R0 is never written, so reading rf_q[0] always yields zero.
    assign wb_live = wb_we && (wb_addr != 5'd0);
    assign rs_val  = (wb_live && (wb_addr == rs_f)) ? wb_data : rf_q[rs_f];
    assign rt_val  = (wb_live && (wb_addr == rt_f)) ? wb_data : rf_q[rt_f];

    // Handshake: instr is consumed on an edge with flush=0, stall=0 and
    // hazard=0; while hazard is high upstream must hold instr unchanged.
    assign hazard = instr_valid && ex_valid_q && (opcode_q == OP_LOAD) &&
                    (dest_addr_q != 5'd0) &&
                    ((dest_addr_q == rs_f) || (dest_addr_q == rt_f));

    always_comb begin
        opcode_d     = opcode_q;
        rs_content_d = rs_content_q;
        rt_content_d = rt_content_q;
        shamt_d      = shamt_q;
        alu_ctrl_d   = alu_ctrl_q;
        immediate_d  = immediate_q;
        dest_addr_d  = dest_addr_q;
        ex_valid_d   = ex_valid_q;
        if (flush || (!stall && (hazard || !instr_valid))) begin
            opcode_d     = '0;
            rs_content_d = '0;
            rt_content_d = '0;
            shamt_d      = '0;
            alu_ctrl_d   = '0;
            immediate_d  = '0;
            dest_addr_d  = '0;
            ex_valid_d   = 1'b0;
        end else if (!stall) begin
            opcode_d     = op_f;
            rs_content_d = rs_val;
            rt_content_d = rt_val;
            shamt_d      = sh_f;
            alu_ctrl_d   = (op_f == OP_RTYPE) ? fn_f : 6'd0;
            immediate_d  = imm_f;
            dest_addr_d  = (op_f == OP_RTYPE) ? rd_f : rt_f;
            ex_valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (wb_live) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q     <= '0;
            rs_content_q <= '0;
            rt_content_q <= '0;
            shamt_q      <= '0;
            alu_ctrl_q   <= '0;
            immediate_q  <= '0;
            dest_addr_q  <= '0;
            ex_valid_q   <= 1'b0;
        end else begin
            opcode_q     <= opcode_d;
            rs_content_q <= rs_content_d;
            rt_content_q <= rt_content_d;
            shamt_q      <= shamt_d;
            alu_ctrl_q   <= alu_ctrl_d;
            immediate_q  <= immediate_d;
            dest_addr_q  <= dest_addr_d;
            ex_valid_q   <= ex_valid_d;
        end
    end

    assign opcode      = opcode_q;
    assign rs_content  = rs_content_q;
    assign rt_content  = rt_content_q;
    assign shamt       = shamt_q;
    assign ALU_control = alu_ctrl_q;
    assign immediate   = immediate_q;
    assign dest_addr   = dest_addr_q;
    assign ex_valid    = ex_valid_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus random traffic, checked against
// an expected-output queue filled from a register-file/pipeline reference model.
module tb_id_stage;

    localparam logic [5:0] OP_LOAD = 6'b100011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid, stall, flush, wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [5:0]  opcode, ALU_control;
    logic [31:0] rs_content, rt_content;
    logic [4:0]  shamt, dest_addr;
    logic [15:0] immediate;
    logic        ex_valid, hazard;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .stall(stall), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data), .opcode(opcode), .rs_content(rs_content),
        .rt_content(rt_content), .shamt(shamt), .ALU_control(ALU_control),
        .immediate(immediate), .dest_addr(dest_addr), .ex_valid(ex_valid),
        .hazard(hazard)
    );

    // Output vector layout: valid[102] op[101:96] rs[95:64] rt[63:32]
    // shamt[31:27] alu[26:21] imm[20:5] dest[4:0]
    wire [102:0] act = {ex_valid, opcode, rs_content, rt_content, shamt,
                        ALU_control, immediate, dest_addr};

    int            errors = 0;
    int            checks = 0;
    logic [102:0]  exp_q[$];
    logic [31:0]   m_rf[32];
    logic [102:0]  m_out;
    logic          last_hz;

    task automatic check(input string name, input logic [102:0] a, input logic [102:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_out   = '0;
        last_hz = 1'b0;
        exp_q.delete();
    endtask

    // Drive one cycle of inputs, predict the registered result and the hazard flag.
    task automatic drive(input logic [31:0] ins, input logic iv, input logic st,
                         input logic fl, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd);
        logic [5:0]   op;
        logic [4:0]   rs, rt;
        logic [31:0]  rsv, rtv;
        logic         hz;
        logic [102:0] nxt;
        @(negedge clk);
        instr = ins; instr_valid = iv; stall = st; flush = fl;
        wb_we = we; wb_addr = wa; wb_data = wd;
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
        rsv = (we && wa != 0 && wa == rs) ? wd : m_rf[rs];
        rtv = (we && wa != 0 && wa == rt) ? wd : m_rf[rt];
        hz = iv && m_out[102] && (m_out[101:96] == OP_LOAD) && (m_out[4:0] != 0) &&
             ((m_out[4:0] == rs) || (m_out[4:0] == rt));
        #1;
        check("hazard", {102'b0, hazard}, {102'b0, hz});
        if (fl)             nxt = '0;
        else if (st)        nxt = m_out;
        else if (hz || !iv) nxt = '0;
        else nxt = {1'b1, op, rsv, rtv, ins[10:6],
                    (op == 6'd0) ? ins[5:0] : 6'd0, ins[15:0],
                    (op == 6'd0) ? ins[15:11] : rt};
        exp_q.push_back(nxt);
        m_out = nxt;
        if (we && wa != 0) m_rf[wa] = wd;
        last_hz = hz;
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        logic [102:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pipe_out", act, e);
        end
    end

    initial begin
        logic [31:0] ins;
        logic        iv;
        logic [5:0]  op;
        rst_n = 1'b0; instr = '0; instr_valid = 0; stall = 0; flush = 0;
        wb_we = 0; wb_addr = '0; wb_data = '0;
        model_reset();
        ins = '0; iv = 0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_out", act, '0);
        @(negedge clk);
        rst_n = 1'b1;

        drive('0, 0, 0, 0, 1, 5'd1, 32'd15);
        drive('0, 0, 0, 0, 1, 5'd2, 32'd12);
        drive(rtype(1, 2, 3, 0, 6'b100000), 1, 0, 0, 0, 0, 0);
        check("rtype_rs", rs_content, 32'd15);
        check("rtype_rt", rt_content, 32'd12);
        check("rtype_alu", ALU_control, 6'b100000);
        check("rtype_dest", dest_addr, 5'd3);
        check("rtype_valid", ex_valid, 1'b1);

        drive('0, 0, 0, 0, 1, 5'd1, 32'd23);
        drive(itype(6'b010010, 1, 4, 16'd19), 1, 0, 0, 0, 0, 0);
        check("itype_rs", rs_content, 32'd23);
        check("itype_imm", immediate, 16'd19);
        check("itype_alu", ALU_control, 6'd0);
        check("itype_dest", dest_addr, 5'd4);

        drive(itype(6'b001000, 5, 7, 16'd0), 1, 0, 0, 1, 5'd5, 32'd35);
        check("bypass_rs", rs_content, 32'd35);
        drive(rtype(0, 0, 8, 0, 6'h20), 1, 0, 0, 1, 5'd0, 32'd99);
        check("r0_rs", rs_content, 32'd0);
        check("r0_rt", rt_content, 32'd0);

        drive('0, 0, 0, 0, 1, 5'd6, 32'd50);
        drive(itype(OP_LOAD, 0, 6, 16'd4), 1, 0, 0, 0, 0, 0);
        drive(rtype(6, 2, 9, 0, 6'h20), 1, 0, 0, 0, 0, 0);
        check("loaduse_bubble", ex_valid, 1'b0);
        drive(rtype(6, 2, 9, 0, 6'h20), 1, 0, 0, 1, 5'd6, 32'd77);
        check("loaduse_issue_valid", ex_valid, 1'b1);
        check("loaduse_issue_rs", rs_content, 32'd77);

        drive(rtype(1, 2, 10, 3, 6'h22), 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive($urandom, 1, 1, 0, 0, 0, 0);
            check("stall_rs", rs_content, 32'd23);
            check("stall_dest", dest_addr, 5'd10);
        end
        drive($urandom, 1, 1, 1, 0, 0, 0);
        check("flush_over_stall", act, '0);

        drive(rtype(1, 2, 11, 0, 6'h20), 1, 0, 0, 0, 0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", act, '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(rtype(1, 2, 12, 0, 6'h20), 1, 0, 0, 0, 0, 0);
        check("post_reset_r1", rs_content, 32'd0);

        for (int n = 0; n < 400; n++) begin
            if (!last_hz) begin
                case ($urandom_range(0, 3))
                    0:       op = 6'b000000;
                    1:       op = OP_LOAD;
                    default: op = 6'($urandom);
                endcase
                ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
                iv  = ($urandom_range(0, 7) != 0);
            end
            drive(ins, iv, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
        end

        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have instr, input, 32, fetched instruction: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm[15:0].
REQ-004 SHALL have instr_valid, input, 1, instr carries a real instruction this cycle.
REQ-005 SHALL have stall, input, 1, downstream hold request.
REQ-006 SHALL have flush, input, 1, squash request from branch resolution.
REQ-007 SHALL have wb_we, input, 1, writeback enable; wb_addr, input, 5, writeback register; wb_data, input, 32, writeback value.
REQ-008 SHALL have opcode, output, 6; rs_content, output, 32; rt_content, output, 32; shamt, output, 5; ALU_control, output, 6; immediate, output, 16; all registered, feeding the ALU.
REQ-009 SHALL have dest_addr, output, 5, registered destination register for the EX stage.
REQ-010 SHALL have ex_valid, output, 1, registered; outputs hold a real instruction.
REQ-011 SHALL have hazard, output, 1, combinational load-use hazard flag; upstream holds instr while high.

Function
REQ-012 SHALL contain a 32x32-bit register file; register 0 reads 0, writes to it ignored.
REQ-013 SHALL write wb_data to wb_addr on the clock edge when wb_we=1 and wb_addr!=0, regardless of stall, flush or hazard.
REQ-014 SHALL bypass writeback on read: if wb_we=1, wb_addr!=0 and wb_addr equals rs (rt), the read value is wb_data, not the stored value.
REQ-015 SHALL decode, per instruction: opcode=instr[31:26]; shamt=instr[10:6]; immediate=instr[15:0]; ALU_control=instr[5:0] when opcode=000000, else 000000.
REQ-016 SHALL set dest_addr=rd when opcode=000000, else rt.
REQ-017 SHALL assert hazard when instr_valid=1, ex_valid=1, registered opcode=100011 (load), dest_addr!=0 and dest_addr equals instr rs or rt.
REQ-018 SHALL apply, each edge, priority flush > stall > hazard > load.
REQ-019 flush=1: SHALL clear ex_valid and zero all data outputs (bubble).
REQ-020 stall=1 (flush=0): SHALL hold all registered outputs unchanged.
REQ-021 hazard=1 (flush=0, stall=0): SHALL insert a bubble (as REQ-019); the held instruction is loaded next cycle once hazard clears.
REQ-022 otherwise: SHALL load decoded fields and register contents, ex_valid=instr_valid; instr_valid=0 loads a bubble.
REQ-023 SHALL have a one-cycle latency: instruction presented in cycle N appears on outputs after edge N (absent flush/stall/hazard).
REQ-024 hazard SHALL be 0 when stall=1 or flush=1 in the same cycle is irrelevant to it: hazard is computed purely from REQ-017 inputs.

Reset
REQ-025 SHALL, while rst_n=0, clear all 32 registers to 0, all registered outputs to 0 and ex_valid to 0, immediately and independently of clk.
REQ-026 SHALL resume normal operation on the first rising edge after rst_n rises; reset mid-stall or mid-hazard discards held state.

Verification
REQ-027 R-type: R1=15, R2=12 written; instr opcode 000000, rs=1, rt=2, rd=3, shamt=0, funct=100000 -> next edge rs_content=15, rt_content=12, ALU_control=100000, dest_addr=3, ex_valid=1.
REQ-028 I-type: opcode 010010, rs=1, rt=4, imm=19 with R1=23 -> rs_content=23, immediate=19, ALU_control=0, dest_addr=4.
REQ-029 Bypass: wb_we=1, wb_addr=5, wb_data=35 same cycle as instr reading rs=5 -> rs_content=35; wb_addr=0, wb_data=99, read R0 -> 0.
REQ-030 Load-use: load (opcode 100011, rt=6) in EX, next instr rs=6 -> hazard=1, bubble (ex_valid=0), then instruction issued with correct R6 once hazard clears.
REQ-031 Priority: stall=1 holds outputs for 3 cycles; flush=1 with stall=1 -> ex_valid=0, outputs 0.
REQ-032 Reset: rst_n low mid-stream, no clk edge -> all outputs 0 immediately; subsequent read of R1 -> 0.
